// File: rtl/fifo_way_arbiter.sv
// fifo_way_arbiter
//
// Purpose:
//   Packs write requests from NUM_REQ pixel producers into the NUM_WAY
//   parallel write lanes of the image address/data FIFO. Grants are handed
//   out round-robin and are capped by a local credit count of free FIFO
//   entries, so the FIFO is never written beyond its capacity. Granted
//   requests are registered onto the lanes, packed from lane 0 upward.
//
// Ports:
//   clk, rst      - single clock, synchronous active-high reset
//   en            - level-sensitive enable for granting
//   req_vld       - per-requester valid
//   req_addr      - per-requester address
//   req_data      - per-requester data
//   req_rdy       - per-requester grant (transfer on req_vld & req_rdy)
//   pop_cnt       - number of FIFO entries read this cycle
//   wen           - registered FIFO lane write enables
//   addr_in       - registered FIFO lane addresses (zero on idle lanes)
//   data_in       - registered FIFO lane data (zero on idle lanes)
//   credit        - free FIFO entries as tracked here
//   busy          - state is not IDLE
//   drained       - one-cycle pulse when DRAIN returns to IDLE
//   err_ovf       - sticky credit overflow flag

`timescale 1ns/1ps

module fifo_way_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int NUM_WAY  = 3,
    parameter int FIFO_LEN = 32,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 6,
    parameter int CW       = $clog2(FIFO_LEN + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [NUM_REQ-1:0]                   req_vld,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]       req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]       req_data,
    output logic [NUM_REQ-1:0]                   req_rdy,
    input  logic [$clog2(NUM_WAY+1)-1:0]         pop_cnt,
    output logic [NUM_WAY-1:0]                   wen,
    output logic [NUM_WAY-1:0][ADDR_W-1:0]       addr_in,
    output logic [NUM_WAY-1:0][DATA_W-1:0]       data_in,
    output logic [CW-1:0]                        credit,
    output logic                                 busy,
    output logic                                 drained,
    output logic                                 err_ovf
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int GW = $clog2(NUM_WAY + 1);
    localparam int LW = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [PW-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]                   credit_q, credit_d;
    logic                            err_ovf_q, err_ovf_d;
    logic                            drained_q, drained_d;
    logic [NUM_WAY-1:0]              wen_q, wen_d;
    logic [NUM_WAY-1:0][ADDR_W-1:0]  addr_q, addr_d;
    logic [NUM_WAY-1:0][DATA_W-1:0]  data_q, data_d;

    logic                            grant_en;
    logic [GW-1:0]                   limit;
    logic [GW-1:0]                   grant_cnt;
    logic [PW:0]                     idx_sum;
    logic [PW-1:0]                   idx;
    logic [PW-1:0]                   last_idx;
    logic                            any_grant;
    logic [CW:0]                     credit_sum;

    // Grant selection. Scan requesters starting at rr_ptr, wrapping modulo
    // NUM_REQ, and hand out at most min(NUM_WAY, credit) grants. Only the
    // registered credit is used so that a same-cycle pop never lets the
    // FIFO be overcommitted. Each grant is packed onto the next free lane.
    // Reset suppresses grants so nothing is accepted while it is asserted.
    always_comb begin
        grant_en  = (state_q == RUN) && !rst;
        limit     = (credit_q < CW'(NUM_WAY)) ? credit_q[GW-1:0] : GW'(NUM_WAY);
        grant_cnt = '0;
        idx_sum   = '0;
        idx       = '0;
        last_idx  = rr_ptr_q;
        any_grant = 1'b0;
        req_rdy   = '0;
        wen_d     = '0;
        addr_d    = '0;
        data_d    = '0;
        if (grant_en) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                idx_sum = {1'b0, rr_ptr_q} + (PW+1)'(j);
                if (idx_sum >= (PW+1)'(NUM_REQ)) begin
                    idx_sum = idx_sum - (PW+1)'(NUM_REQ);
                end
                idx = idx_sum[PW-1:0];
                if (req_vld[idx] && (grant_cnt < limit)) begin
                    req_rdy[idx]                 = 1'b1;
                    wen_d[grant_cnt[LW-1:0]]     = 1'b1;
                    addr_d[grant_cnt[LW-1:0]]    = req_addr[idx];
                    data_d[grant_cnt[LW-1:0]]    = req_data[idx];
                    grant_cnt                    = grant_cnt + 1'b1;
                    last_idx                     = idx;
                    any_grant                    = 1'b1;
                end
            end
        end
    end

    // Round-robin pointer moves just past the last granted requester so the
    // next scan starts with whoever was skipped or not yet reached.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_grant) begin
            rr_ptr_d = (last_idx == PW'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
        end
    end

    // Credit bookkeeping runs in every state: grants consume entries and
    // FIFO pops return them. A return that would exceed the FIFO depth
    // means the FIFO reported more pops than writes; clamp and flag it.
    always_comb begin
        credit_sum = {1'b0, credit_q} - (CW+1)'(grant_cnt) + (CW+1)'(pop_cnt);
        credit_d   = credit_sum[CW-1:0];
        err_ovf_d  = err_ovf_q;
        if (credit_sum > (CW+1)'(FIFO_LEN)) begin
            credit_d  = CW'(FIFO_LEN);
            err_ovf_d = 1'b1;
        end
    end

    // Control FSM. DRAIN waits for every outstanding FIFO entry to be popped
    // before returning to IDLE; a re-enable during DRAIN takes priority and
    // resumes granting immediately.
    always_comb begin
        state_d   = state_q;
        drained_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                end else if (credit_q == CW'(FIFO_LEN)) begin
                    state_d   = IDLE;
                    drained_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset discards any lane writes in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            credit_q  <= CW'(FIFO_LEN);
            err_ovf_q <= 1'b0;
            drained_q <= 1'b0;
            wen_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            credit_q  <= credit_d;
            err_ovf_q <= err_ovf_d;
            drained_q <= drained_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign wen     = wen_q;
    assign addr_in = addr_q;
    assign data_in = data_q;
    assign credit  = credit_q;
    assign busy    = (state_q != IDLE);
    assign drained = drained_q;
    assign err_ovf = err_ovf_q;

endmodule

// File: tb/tb_fifo_way_arbiter.sv
// tb_fifo_way_arbiter
//
// Directed bench for fifo_way_arbiter with hand-computed expectations.
// Requester i drives address i*4+1 and data 63-i so lane contents identify
// which requester landed on which lane.

`timescale 1ns/1ps

module tb_fifo_way_arbiter;

    logic             clk;
    logic             rst;
    logic             en;
    logic [7:0]       reqVld;
    logic [7:0][5:0]  reqAddr;
    logic [7:0][5:0]  reqData;
    logic [7:0]       reqRdy;
    logic [1:0]       popCnt;
    logic [2:0]       wen;
    logic [2:0][5:0]  addrIn;
    logic [2:0][5:0]  dataIn;
    logic [5:0]       credit;
    logic             busy;
    logic             drained;
    logic             errOvf;

    int checkCount;
    int errorCount;
    int expCredit;

    fifo_way_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req_vld  (reqVld),
        .req_addr (reqAddr),
        .req_data (reqData),
        .req_rdy  (reqRdy),
        .pop_cnt  (popCnt),
        .wen      (wen),
        .addr_in  (addrIn),
        .data_in  (dataIn),
        .credit   (credit),
        .busy     (busy),
        .drained  (drained),
        .err_ovf  (errOvf)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] time limit reached");
    end

    function automatic logic [5:0] expA(input int i);
        return 6'(i * 4 + 1);
    endfunction

    function automatic logic [5:0] expD(input int i);
        return 6'(63 - i);
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Drive all inputs at once, away from the clock edge.
    task automatic applyStimulus(input logic rstV, input logic enV,
                                 input logic [7:0] vldV, input logic [1:0] popV);
        rst    = rstV;
        en     = enV;
        reqVld = vldV;
        popCnt = popV;
    endtask

    // Advance one cycle and sample just after the active edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        for (int i = 0; i < 8; i++) begin
            reqAddr[i] = expA(i);
            reqData[i] = expD(i);
        end

        // Reset state
        applyStimulus(1'b1, 1'b0, 8'h00, 2'd0);
        repeat (2) stepClock();
        applyStimulus(1'b0, 1'b0, 8'hFF, 2'd0);
        #1;
        checkOutput("reset_wen", 64'(wen), 64'd0);
        checkOutput("reset_addr", 64'(addrIn), 64'd0);
        checkOutput("reset_credit", 64'(credit), 64'd32);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_drained", 64'(drained), 64'd0);
        checkOutput("reset_err", 64'(errOvf), 64'd0);
        checkOutput("idle_rdy", 64'(reqRdy), 64'd0);

        // Full round-robin with all requesters valid
        applyStimulus(1'b0, 1'b1, 8'hFF, 2'd0);
        #1;
        checkOutput("en_rise_rdy", 64'(reqRdy), 64'd0);
        stepClock();
        checkOutput("run_busy", 64'(busy), 64'd1);
        checkOutput("c1_rdy", 64'(reqRdy), 64'h07);
        checkOutput("c1_wen", 64'(wen), 64'd0);
        stepClock();
        checkOutput("c2_wen", 64'(wen), 64'h7);
        checkOutput("c2_addr", 64'(addrIn), 64'({expA(2), expA(1), expA(0)}));
        checkOutput("c2_data", 64'(dataIn), 64'({expD(2), expD(1), expD(0)}));
        checkOutput("c2_credit", 64'(credit), 64'd29);
        checkOutput("c2_rdy", 64'(reqRdy), 64'h38);
        stepClock();
        checkOutput("c3_wen", 64'(wen), 64'h7);
        checkOutput("c3_addr", 64'(addrIn), 64'({expA(5), expA(4), expA(3)}));
        checkOutput("c3_credit", 64'(credit), 64'd26);
        checkOutput("c3_rdy", 64'(reqRdy), 64'hC1);
        stepClock();
        checkOutput("c4_wen", 64'(wen), 64'h7);
        checkOutput("c4_addr", 64'(addrIn), 64'({expA(0), expA(7), expA(6)}));
        checkOutput("c4_credit", 64'(credit), 64'd23);
        checkOutput("c4_rdy", 64'(reqRdy), 64'h0E);

        // Credit exhaustion with no pops
        expCredit = 23;
        for (int k = 0; k < 7; k++) begin
            stepClock();
            expCredit = expCredit - 3;
            checkOutput("exh_credit", 64'(credit), 64'(expCredit));
            checkOutput("exh_wen", 64'(wen), 64'h7);
        end
        checkOutput("exh_partial_rdy", 64'(reqRdy), 64'hC0);
        stepClock();
        checkOutput("exh_partial_wen", 64'(wen), 64'h3);
        checkOutput("exh_partial_addr", 64'(addrIn), 64'({6'd0, expA(7), expA(6)}));
        checkOutput("exh_zero_credit", 64'(credit), 64'd0);
        checkOutput("exh_zero_rdy", 64'(reqRdy), 64'd0);
        stepClock();
        checkOutput("stall_wen", 64'(wen), 64'd0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 2'd1);
        #1;
        checkOutput("samecycle_pop_rdy", 64'(reqRdy), 64'd0);
        stepClock();
        applyStimulus(1'b0, 1'b1, 8'hFF, 2'd0);
        #1;
        checkOutput("pop1_credit", 64'(credit), 64'd1);
        checkOutput("pop1_rdy", 64'(reqRdy), 64'h01);
        stepClock();
        checkOutput("pop1_wen", 64'(wen), 64'h1);
        checkOutput("pop1_addr", 64'(addrIn), 64'({6'd0, 6'd0, expA(0)}));
        checkOutput("pop1_credit_used", 64'(credit), 64'd0);

        // Sparse requests: steer rr_ptr to 3, then req 2 and req 6
        applyStimulus(1'b0, 1'b1, 8'h00, 2'd3);
        stepClock();
        checkOutput("sp_credit3", 64'(credit), 64'd3);
        applyStimulus(1'b0, 1'b1, 8'h06, 2'd2);
        #1;
        checkOutput("sp_pre_rdy", 64'(reqRdy), 64'h06);
        stepClock();
        checkOutput("sp_pre_credit", 64'(credit), 64'd3);
        checkOutput("sp_pre_addr", 64'(addrIn), 64'({6'd0, expA(2), expA(1)}));
        applyStimulus(1'b0, 1'b1, 8'h44, 2'd0);
        #1;
        checkOutput("sp_rdy", 64'(reqRdy), 64'h44);
        stepClock();
        checkOutput("sp_wen", 64'(wen), 64'h3);
        checkOutput("sp_addr", 64'(addrIn), 64'({6'd0, expA(2), expA(6)}));
        checkOutput("sp_data", 64'(dataIn), 64'({6'd0, expD(2), expD(6)}));
        checkOutput("sp_credit", 64'(credit), 64'd1);
        applyStimulus(1'b0, 1'b1, 8'h0C, 2'd0);
        #1;
        checkOutput("sp_rrptr_rdy", 64'(reqRdy), 64'h08);
        stepClock();
        checkOutput("sp_rrptr_addr", 64'(addrIn), 64'({6'd0, 6'd0, expA(3)}));

        // Simultaneous grants and pops
        applyStimulus(1'b0, 1'b1, 8'h00, 2'd3);
        repeat (3) stepClock();
        applyStimulus(1'b0, 1'b1, 8'h00, 2'd1);
        stepClock();
        checkOutput("sim_credit10", 64'(credit), 64'd10);
        applyStimulus(1'b0, 1'b1, 8'hFF, 2'd2);
        #1;
        checkOutput("sim_rdy", 64'(reqRdy), 64'h70);
        stepClock();
        checkOutput("sim_credit9", 64'(credit), 64'd9);
        checkOutput("sim_wen", 64'(wen), 64'h7);
        applyStimulus(1'b0, 1'b1, 8'h00, 2'd3);
        repeat (7) stepClock();
        applyStimulus(1'b0, 1'b1, 8'h00, 2'd1);
        stepClock();
        checkOutput("ovf_credit31", 64'(credit), 64'd31);
        checkOutput("ovf_err_before", 64'(errOvf), 64'd0);
        applyStimulus(1'b0, 1'b1, 8'h00, 2'd3);
        stepClock();
        checkOutput("ovf_credit_sat", 64'(credit), 64'd32);
        checkOutput("ovf_err", 64'(errOvf), 64'd1);
        applyStimulus(1'b0, 1'b1, 8'h00, 2'd0);
        stepClock();
        checkOutput("ovf_err_sticky", 64'(errOvf), 64'd1);

        // Drain from credit 20
        applyStimulus(1'b0, 1'b1, 8'hFF, 2'd0);
        repeat (4) stepClock();
        checkOutput("dr_credit20", 64'(credit), 64'd20);
        applyStimulus(1'b0, 1'b0, 8'h00, 2'd0);
        stepClock();
        checkOutput("dr_busy", 64'(busy), 64'd1);
        checkOutput("dr_no_write", 64'(wen), 64'd0);
        checkOutput("dr_credit_hold", 64'(credit), 64'd20);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 8'hFF, 2'd3);
            #1;
            checkOutput("dr_rdy", 64'(reqRdy), 64'd0);
            checkOutput("dr_no_pulse", 64'(drained), 64'd0);
            stepClock();
            checkOutput("dr_credit", 64'(credit), 64'(20 + 3 * (k + 1)));
        end
        applyStimulus(1'b0, 1'b0, 8'hFF, 2'd0);
        #1;
        checkOutput("dr_full_busy", 64'(busy), 64'd1);
        checkOutput("dr_full_rdy", 64'(reqRdy), 64'd0);
        stepClock();
        checkOutput("dr_pulse", 64'(drained), 64'd1);
        checkOutput("dr_idle_busy", 64'(busy), 64'd0);
        stepClock();
        checkOutput("dr_pulse_end", 64'(drained), 64'd0);
        checkOutput("dr_stay_idle", 64'(busy), 64'd0);

        // Reset in the middle of a burst
        applyStimulus(1'b0, 1'b1, 8'hFF, 2'd0);
        stepClock();
        checkOutput("mb_rdy", 64'(reqRdy), 64'h38);
        stepClock();
        checkOutput("mb_wen", 64'(wen), 64'h7);
        checkOutput("mb_credit", 64'(credit), 64'd29);
        applyStimulus(1'b1, 1'b1, 8'hFF, 2'd0);
        #1;
        checkOutput("mb_rst_rdy", 64'(reqRdy), 64'd0);
        stepClock();
        applyStimulus(1'b0, 1'b1, 8'hFF, 2'd0);
        #1;
        checkOutput("mb_rst_wen", 64'(wen), 64'd0);
        checkOutput("mb_rst_addr", 64'(addrIn), 64'd0);
        checkOutput("mb_rst_credit", 64'(credit), 64'd32);
        checkOutput("mb_rst_busy", 64'(busy), 64'd0);
        checkOutput("mb_rst_err", 64'(errOvf), 64'd0);
        stepClock();
        checkOutput("mb_rrptr_rdy", 64'(reqRdy), 64'h07);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
